bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master arbiter/sequencer for the SoC memory/peripheral bus. Master 0 is the CPU
//  and master 1 is a secondary requester such as a UART program loader. The block grants
//  one master at a time and drives single-cycle read/write strobes onto the shared bus.
//  It waits a fixed read latency, returns read data and pulses a per-master ack.
//  It sits between the masters and the address-decoded progmem/GPIO fabric.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width (byte strobes = DW/8)
//  RD_LAT    1   slave read latency in cycles from bus_rstrb to valid bus_rdata; legal 1..15
//  PRIO_MODE 0   0 = round-robin; 1 = fixed priority, m0 always wins ties
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst        in   1      asynchronous, active-low reset
//  m0_req     in   1      m0 request; command held stable until m0_ack
//  m0_addr    in   AW     m0 address
//  m0_wdata   in   DW     m0 write data
//  m0_wstrb   in   DW/8   m0 byte write enables (nonzero = write)
//  m0_rstrb   in   1      m0 read request
//  m0_rdata   out  DW     m0 read data, registered
//  m0_ack     out  1      one-cycle completion pulse to m0
//  m1_*       same set as m0_* for master 1
//  bus_addr   out  AW     shared bus address
//  bus_wdata  out  DW     shared bus write data
//  bus_wstrb  out  DW/8   shared bus byte write strobe, one-cycle pulse
//  bus_rstrb  out  1      shared bus read strobe, one-cycle pulse
//  bus_rdata  in   DW     shared bus read data (already muxed by address decode)
//  grant      out  2      one-hot current owner: [0]=m0, [1]=m1; 00 when idle
//  busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; grant=00; all strobes, acks, bus_addr, bus_wdata,
//   m0_rdata and m1_rdata = 0; last_grant=m1, so m0 wins the first tie.
//  FSM IDLE -> ISSUE -> [WAIT] -> DONE -> IDLE.
//  IDLE: sample m0_req/m1_req. If exactly one is asserted, grant that master.
//   If both are asserted: PRIO_MODE=0 grants the master not in last_grant; PRIO_MODE=1 grants m0.
//   The grant is registered, then the FSM goes to ISSUE. No request: stay in IDLE.
//  ISSUE (1 cycle): bus_addr/bus_wdata follow the granted master.
//   If wstrb!=0: bus_wstrb=wstrb, bus_rstrb=0, next state DONE.
//   Else if rstrb=1: bus_rstrb=1, load cnt=RD_LAT-1, next state WAIT.
//   Else (empty command): no strobe, next state DONE.
//   If both wstrb!=0 and rstrb=1: the write wins and rstrb is suppressed.
//  WAIT: lasts RD_LAT cycles; cnt decrements each cycle. When cnt==0, capture bus_rdata
//   into the granted master's rdata register and go to DONE.
//  DONE (1 cycle): the granted master's ack=1; last_grant<=grant; next state IDLE.
//  Strobes are 0 outside ISSUE. bus_addr/bus_wdata are held from ISSUE through DONE
//   and are 0 in IDLE.
//  Latency, counted from the IDLE cycle that samples req: write ack at +2 cycles;
//   read ack at +2+RD_LAT cycles.
//  Back-to-back: a master sees a new request sampled in the IDLE cycle after its ack.
//   Minimum turnaround is 3 cycles for writes and 3+RD_LAT cycles for reads.
//   Under round-robin with both masters requesting continuously, grants strictly alternate.
//  Request dropped after ISSUE: the transaction still completes and ack still pulses.
//   A request dropped in IDLE before sampling is simply not served.
//  Non-granted master: ack stays 0 and its rdata is unchanged. Each rdata register
//   changes only on that master's read completion.
//  Reset asserted mid-transaction: returns immediately to reset values and no ack is issued.
//   The slave may already have taken the write; masters must reissue the command.
//  cnt width: 4 bits.
// TESTING
//  Reset: rst=0 with m0_req=1 -> grant=00, busy=0, all strobes/acks=0; release -> m0 served first.
//  m0 write: addr=0x1000_0000, wdata=0x2A, wstrb=4'hF -> bus_wstrb=F for exactly 1 cycle; m0_ack at +2.
//  m1 read, RD_LAT=3: slave returns 0xDEAD_BEEF 3 cycles after bus_rstrb -> m1_rdata=0xDEADBEEF,
//   m1_ack at +5; m0_rdata unchanged.
//  Both request continuously, PRIO_MODE=0 -> grants alternate m0,m1,m0,m1; PRIO_MODE=1 -> m0 only.
//  Request with wstrb=4'h3 and rstrb=1 -> only bus_wstrb=3 pulses, bus_rstrb stays 0; ack at +2.
//  rst pulsed low during WAIT -> no ack; state=IDLE; a re-issued read completes normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter/sequencer: grants one master at a time, issues single-cycle
// read/write strobes on the shared bus, waits RD_LAT for read data and acks the owner.
module bus_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic            m0_rstrb,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_ack,

    input  logic            m1_req,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic            m1_rstrb,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_ack,

    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_wstrb,
    output logic            bus_rstrb,
    input  logic [DW-1:0]   bus_rdata,

    output logic [1:0]      grant,
    output logic            busy
);

    localparam int SW = DW / 8;
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            last_grant;   // 0: m0 was served last, 1: m1

    logic            pick_m1;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [SW-1:0]   sel_wstrb;
    logic            sel_rstrb;

    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    always_comb begin
        pick_m1 = m1_req;
        if (m0_req && m1_req) begin
            pick_m1 = (PRIO_MODE == 0) && !last_grant;
        end
        sel_addr  = pick_m1 ? m1_addr  : m0_addr;
        sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
        sel_wstrb = pick_m1 ? m1_wstrb : m0_wstrb;
        sel_rstrb = pick_m1 ? m1_rstrb : m0_rstrb;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            busy       <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_wstrb  <= '0;
            bus_rstrb  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
        end else begin
            bus_wstrb <= '0;
            bus_rstrb <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;

            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant     <= pick_m1 ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        bus_addr  <= sel_addr;
                        bus_wdata <= sel_wdata;
                        // A write wins over a simultaneous read request.
                        if (sel_wstrb != '0) begin
                            bus_wstrb <= sel_wstrb;
                        end else if (sel_rstrb) begin
                            bus_rstrb <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (bus_rstrb) begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end else begin
                        m0_ack <= grant[0];
                        m1_ack <= grant[1];
                        state  <= DONE;
                    end
                end

                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (grant[0]) begin
                            m0_rdata <= bus_rdata;
                        end else begin
                            m1_rdata <= bus_rdata;
                        end
                        m0_ack <= grant[0];
                        m1_ack <= grant[1];
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    last_grant <= grant[1];
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    bus_addr   <= '0;
                    bus_wdata  <= '0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin RD_LAT=3 instance and a fixed-priority RD_LAT=1
// instance, each checked every cycle against a transaction-schedule model.
module tb_bus_arbiter;

    typedef enum int { K_WR, K_RD, K_NOP } kind_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        req   [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [3:0]  wstrb [2][2];
    logic        rstrb [2][2];
    logic [31:0] rdata [2][2];
    logic        ack   [2][2];

    logic [31:0] bus_addr  [2];
    logic [31:0] bus_wdata [2];
    logic [3:0]  bus_wstrb [2];
    logic        bus_rstrb [2];
    logic [31:0] bus_rdata [2];
    logic [1:0]  grant     [2];
    logic        busy      [2];

    logic [31:0] slave_data [2];
    logic [2:0]  spipe      [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(req[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
        .m0_wstrb(wstrb[0][0]), .m0_rstrb(rstrb[0][0]), .m0_rdata(rdata[0][0]), .m0_ack(ack[0][0]),
        .m1_req(req[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
        .m1_wstrb(wstrb[0][1]), .m1_rstrb(rstrb[0][1]), .m1_rdata(rdata[0][1]), .m1_ack(ack[0][1]),
        .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]), .bus_wstrb(bus_wstrb[0]),
        .bus_rstrb(bus_rstrb[0]), .bus_rdata(bus_rdata[0]),
        .grant(grant[0]), .busy(busy[0])
    );

    bus_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(req[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
        .m0_wstrb(wstrb[1][0]), .m0_rstrb(rstrb[1][0]), .m0_rdata(rdata[1][0]), .m0_ack(ack[1][0]),
        .m1_req(req[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
        .m1_wstrb(wstrb[1][1]), .m1_rstrb(rstrb[1][1]), .m1_rdata(rdata[1][1]), .m1_ack(ack[1][1]),
        .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]), .bus_wstrb(bus_wstrb[1]),
        .bus_rstrb(bus_rstrb[1]), .bus_rdata(bus_rdata[1]),
        .grant(grant[1]), .busy(busy[1])
    );

    // Slave: data is valid only exactly RD_LAT cycles after the read strobe.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) spipe[d] <= 3'b000;
            else      spipe[d] <= {spipe[d][1:0], bus_rstrb[d]};
        end
    end
    assign bus_rdata[0] = spipe[0][2] ? slave_data[0] : 32'h5555_5555;
    assign bus_rdata[1] = spipe[1][0] ? slave_data[1] : 32'h5555_5555;

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic bit fixed_prio(input int d);
        return d == 1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Model: one scheduled transaction per instance (sample cycle, ack cycle, owner, command).
    bit          m_act   [2];
    int          m_start [2];
    int          m_end   [2];
    int          m_who   [2];
    kind_t       m_kind  [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    int          m_last  [2];
    logic [31:0] m_rdata [2][2];

    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_rstrb, e_busy, e_ack0, e_ack1;
    logic [1:0]  e_grant;
    int          w;

    logic [1:0]  prev_grant [2];
    logic [1:0]  glog0 [$];
    logic [1:0]  glog1 [$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rstrb = 1'b0;
            e_busy = 1'b0; e_grant = 2'b00; e_ack0 = 1'b0; e_ack1 = 1'b0;
            if (!rst) begin
                m_act[d] = 1'b0;
                m_last[d] = 1;
                m_rdata[d][0] = '0;
                m_rdata[d][1] = '0;
            end else if (m_act[d]) begin
                e_busy  = 1'b1;
                e_grant = (m_who[d] == 1) ? 2'b10 : 2'b01;
                e_addr  = m_addr[d];
                e_wdata = m_wdata[d];
                if (cyc == m_start[d] + 1) begin
                    if (m_kind[d] == K_WR) e_wstrb = m_wstrb[d];
                    if (m_kind[d] == K_RD) e_rstrb = 1'b1;
                end
                if (cyc == m_end[d]) begin
                    if (m_who[d] == 0) e_ack0 = 1'b1;
                    else               e_ack1 = 1'b1;
                    if (m_kind[d] == K_RD) m_rdata[d][m_who[d]] = slave_data[d];
                end
            end

            check($sformatf("d%0d_busy", d),      busy[d],      e_busy);
            check($sformatf("d%0d_grant", d),     grant[d],     e_grant);
            check($sformatf("d%0d_bus_addr", d),  bus_addr[d],  e_addr);
            check($sformatf("d%0d_bus_wdata", d), bus_wdata[d], e_wdata);
            check($sformatf("d%0d_bus_wstrb", d), bus_wstrb[d], e_wstrb);
            check($sformatf("d%0d_bus_rstrb", d), bus_rstrb[d], e_rstrb);
            check($sformatf("d%0d_m0_ack", d),    ack[d][0],    e_ack0);
            check($sformatf("d%0d_m1_ack", d),    ack[d][1],    e_ack1);
            check($sformatf("d%0d_m0_rdata", d),  rdata[d][0],  m_rdata[d][0]);
            check($sformatf("d%0d_m1_rdata", d),  rdata[d][1],  m_rdata[d][1]);

            if (grant[d] != 2'b00 && prev_grant[d] == 2'b00) begin
                if (d == 0) glog0.push_back(grant[d]);
                else        glog1.push_back(grant[d]);
            end
            prev_grant[d] = grant[d];

            if (rst) begin
                if (m_act[d] && cyc == m_end[d]) begin
                    m_last[d] = m_who[d];
                    m_act[d]  = 1'b0;
                end else if (!m_act[d] && (req[d][0] || req[d][1])) begin
                    if (req[d][0] && req[d][1])
                        w = fixed_prio(d) ? 0 : 1 - m_last[d];
                    else
                        w = req[d][1] ? 1 : 0;
                    m_act[d]   = 1'b1;
                    m_start[d] = cyc;
                    m_who[d]   = w;
                    m_addr[d]  = addr[d][w];
                    m_wdata[d] = wdata[d][w];
                    m_wstrb[d] = wstrb[d][w];
                    if (wstrb[d][w] != 4'h0) m_kind[d] = K_WR;
                    else if (rstrb[d][w])    m_kind[d] = K_RD;
                    else                     m_kind[d] = K_NOP;
                    m_end[d] = cyc + 2 + ((m_kind[d] == K_RD) ? lat_of(d) : 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input int m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic rs);
        addr[d][m]  = a;
        wdata[d][m] = wd;
        wstrb[d][m] = ws;
        rstrb[d][m] = rs;
        req[d][m]   = 1'b1;
    endtask

    // Counts cycles until ack (bounded) and the strobe pulses seen meanwhile; drops req on ack.
    task automatic wait_ack(input int d, input int m, output int lat, output int nw,
                            output logic [3:0] wv, output int nr);
        lat = 0; nw = 0; nr = 0; wv = 4'h0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus_wstrb[d] != 4'h0) begin
                nw++;
                wv = bus_wstrb[d];
            end
            if (bus_rstrb[d]) nr++;
            if (ack[d][m]) begin
                lat = i;
                req[d][m] = 1'b0;
                return;
            end
        end
        check($sformatf("ack_timeout_d%0d_m%0d", d, m), ack[d][m], 1'b1);
        req[d][m] = 1'b0;
    endtask

    task automatic run_xact(input int d, input int m, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, input logic rs, output int lat, output int nw,
                            output logic [3:0] wv, output int nr);
        issue(d, m, a, wd, ws, rs);
        wait_ack(d, m, lat, nw, wv, nr);
        tick();
    endtask

    int         lat, nw, nr;
    logic [3:0] wv;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                req[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0;
                wstrb[d][m] = 4'h0; rstrb[d][m] = 1'b0;
            end
            slave_data[d] = '0;
            prev_grant[d] = 2'b00;
            m_act[d] = 1'b0;
            m_last[d] = 1;
        end

        // Reset held with m0 already requesting: nothing moves.
        issue(0, 0, 32'h1000_0000, 32'h0000_002A, 4'hF, 1'b0);
        repeat (3) tick();
        check("rst_grant", grant[0], 2'b00);
        check("rst_busy", busy[0], 1'b0);
        check("rst_wstrb", bus_wstrb[0], 4'h0);
        check("rst_m0_ack", ack[0][0], 1'b0);

        // Release: m0 write served first, strobe for one cycle, ack at +2.
        rst = 1'b1;
        wait_ack(0, 0, lat, nw, wv, nr);
        tick();
        check("m0_wr_lat", lat, 2);
        check("m0_wr_nwstrb", nw, 1);
        check("m0_wr_wstrb", wv, 4'hF);
        check("m0_wr_nrstrb", nr, 0);

        // m1 read with RD_LAT=3 and RD_LAT=1.
        slave_data[0] = 32'hDEAD_BEEF;
        run_xact(0, 1, 32'h0000_0040, 32'h0, 4'h0, 1'b1, lat, nw, wv, nr);
        check("m1_rd3_lat", lat, 5);
        check("m1_rd3_nrstrb", nr, 1);
        check("m1_rd3_rdata", rdata[0][1], 32'hDEAD_BEEF);
        check("m1_rd3_m0_rdata", rdata[0][0], 32'h0);

        slave_data[1] = 32'h1234_5678;
        run_xact(1, 1, 32'h0000_0044, 32'h0, 4'h0, 1'b1, lat, nw, wv, nr);
        check("m1_rd1_lat", lat, 3);
        check("m1_rd1_rdata", rdata[1][1], 32'h1234_5678);

        // Write and read requested together: only the write strobe appears.
        run_xact(0, 1, 32'h2000_0000, 32'h0000_0055, 4'h3, 1'b1, lat, nw, wv, nr);
        check("wr_rd_lat", lat, 2);
        check("wr_rd_nwstrb", nw, 1);
        check("wr_rd_wstrb", wv, 4'h3);
        check("wr_rd_nrstrb", nr, 0);
        check("wr_rd_m1_rdata", rdata[0][1], 32'hDEAD_BEEF);

        // Empty command still completes.
        run_xact(1, 0, 32'h0000_0080, 32'h0, 4'h0, 1'b0, lat, nw, wv, nr);
        check("nop_lat", lat, 2);
        check("nop_strobes", nw + nr, 0);

        // Both masters requesting continuously on both instances.
        glog0.delete();
        glog1.delete();
        issue(0, 0, 32'h0000_0100, 32'h0000_00A0, 4'hF, 1'b0);
        issue(0, 1, 32'h0000_0200, 32'h0000_00B1, 4'hF, 1'b0);
        issue(1, 0, 32'h0000_0300, 32'h0000_00C0, 4'h1, 1'b0);
        issue(1, 1, 32'h0000_0400, 32'h0000_00D1, 4'h2, 1'b0);
        repeat (14) tick();
        for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) req[d][m] = 1'b0;
        for (int i = 0; i < 20 && (busy[0] || busy[1]); i++) tick();
        check("contend_idle", {busy[0], busy[1]}, 2'b00);
        check("rr_glog_n_ok", glog0.size() >= 4, 1'b1);
        check("fp_glog_n_ok", glog1.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < glog0.size(); i++)
            check($sformatf("rr_grant_%0d", i), glog0[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        for (int i = 0; i < 4 && i < glog1.size(); i++)
            check($sformatf("fp_grant_%0d", i), glog1[i], 2'b01);
        tick();

        // Reset during WAIT: no ack, back to idle, reissued read completes.
        slave_data[0] = 32'hCAFE_F00D;
        issue(0, 0, 32'h3000_0000, 32'h0, 4'h0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_grant", grant[0], 2'b00);
        check("midrst_ack", ack[0][0], 1'b0);
        req[0][0] = 1'b0;
        repeat (2) tick();
        check("midrst_ack_hold", ack[0][0], 1'b0);
        check("midrst_m0_rdata", rdata[0][0], 32'h0);
        rst = 1'b1;
        run_xact(0, 0, 32'h3000_0000, 32'h0, 4'h0, 1'b1, lat, nw, wv, nr);
        check("reissue_lat", lat, 5);
        check("reissue_rdata", rdata[0][0], 32'hCAFE_F00D);
        check("reissue_m1_rdata", rdata[0][1], 32'h0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
